// File: rtl/merger_select_ctrl_pkg.sv
// merger_select_ctrl_pkg: shared state encoding and merge-tree tuple/batch constants
package merger_select_ctrl_pkg;
  typedef enum logic {
    RUN    = 1'b0,
    TERM_B = 1'b1
  } state_t;
  localparam int BATCH_SIZE = 16;
  localparam int DATA_WIDTH = 128;
  localparam int KEY_WIDTH  = 80;
endpackage

// File: rtl/merger_select_ctrl.sv
// merger_select_ctrl: 2-to-1 merger source selection, stall and end-of-stream flush control
module merger_select_ctrl
  import merger_select_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fifo_out_full,
  input  logic                   i_a_min_zero,
  input  logic                   i_b_min_zero,
  input  logic                   i_a_lte_b,
  input  logic                   i_a_empty,
  input  logic                   i_b_empty,
  output logic                   select_A,
  output logic                   stall,
  output logic                   switch_output,
  output logic [COUNT_WIDTH-1:0] o_stream_count
);
  state_t state, state_nxt;
  logic   run, both_zero;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= RUN;
      o_stream_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == TERM_B && !stall) o_stream_count <= o_stream_count + 1'b1;
    end
  end
  always_comb begin
    run           = state == RUN;
    both_zero     = i_a_min_zero & i_b_min_zero;
    stall         = i_rst | i_fifo_out_full | i_b_empty | (run & i_a_empty);
    select_A      = !i_rst & run & (both_zero | (!i_a_min_zero & (i_b_min_zero | i_a_lte_b)));
    switch_output = !i_rst & run & both_zero;
    state_nxt     = stall ? state : (run && both_zero) ? TERM_B : RUN;
  end
endmodule

// File: tb/tb_merger_select_ctrl.sv
// tb_merger_select_ctrl: randomized and directed self-check of merger_select_ctrl against a behavioural model
module tb_merger_select_ctrl;
  localparam int CW = 8;
  logic i_clk = 0;
  logic i_rst = 1, i_fifo_out_full = 0, i_a_min_zero = 0, i_b_min_zero = 0;
  logic i_a_lte_b = 0, i_a_empty = 0, i_b_empty = 0;
  logic select_A, stall, switch_output;
  logic [CW-1:0] o_stream_count;
  int checks = 0, errors = 0;
  bit awaiting_b_term = 0;
  int seqs_done = 0;
  logic e_sel, e_stall, e_sw;
  logic [CW-1:0] e_cnt;

  merger_select_ctrl #(.COUNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_fifo_out_full(i_fifo_out_full),
    .i_a_min_zero(i_a_min_zero), .i_b_min_zero(i_b_min_zero), .i_a_lte_b(i_a_lte_b),
    .i_a_empty(i_a_empty), .i_b_empty(i_b_empty), .select_A(select_A), .stall(stall),
    .switch_output(switch_output), .o_stream_count(o_stream_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_outputs();
    e_cnt = CW'(seqs_done % (1 << CW));
    if (i_rst) begin
      e_stall = 1; e_sel = 0; e_sw = 0;
    end else if (awaiting_b_term) begin
      e_stall = i_fifo_out_full | i_b_empty; e_sel = 0; e_sw = 0;
    end else begin
      e_stall = i_fifo_out_full | i_a_empty | i_b_empty;
      e_sw = i_a_min_zero & i_b_min_zero;
      if (i_a_min_zero && i_b_min_zero) e_sel = 1;
      else if (i_a_min_zero) e_sel = 0;
      else if (i_b_min_zero) e_sel = 1;
      else e_sel = i_a_lte_b;
    end
  endtask

  task automatic cyc(input logic rst, full, az, bz, lte, ae, be);
    @(posedge i_clk);
    model_outputs();
    if (i_rst) begin
      awaiting_b_term = 0; seqs_done = 0;
    end else if (!e_stall) begin
      if (awaiting_b_term) begin awaiting_b_term = 0; seqs_done++; end
      else if (i_a_min_zero && i_b_min_zero) awaiting_b_term = 1;
    end
    #1;
    i_rst = rst; i_fifo_out_full = full; i_a_min_zero = az; i_b_min_zero = bz;
    i_a_lte_b = lte; i_a_empty = ae; i_b_empty = be;
    @(negedge i_clk);
    model_outputs();
    chk("stall", CW'(stall), CW'(e_stall));
    if (!e_stall) chk("select_A", CW'(select_A), CW'(e_sel));
    chk("switch_output", CW'(switch_output), CW'(e_sw));
    chk("stream_count", o_stream_count, e_cnt);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_stall", CW'(stall), 1);
    chk("lit_rst_sel", CW'(select_A), 0);
    chk("lit_rst_sw", CW'(switch_output), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lit_cnt0", o_stream_count, 0);
    chk("lit_lte_sel", CW'(select_A), 1);
    chk("lit_lte_stall", CW'(stall), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_gt_sel", CW'(select_A), 0);
    cyc(0, 0, 0, 0, 1, 0, 1);
    chk("lit_bempty_stall", CW'(stall), 1);
    cyc(0, 1, 0, 0, 1, 0, 0);
    chk("lit_full_stall", CW'(stall), 1);
    cyc(0, 0, 1, 0, 1, 0, 0);
    chk("lit_azero_sel", CW'(select_A), 0);
    chk("lit_azero_sw", CW'(switch_output), 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("lit_bzero_sel", CW'(select_A), 1);
    chk("lit_bzero_sw", CW'(switch_output), 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("lit_eos1_sel", CW'(select_A), 1);
    chk("lit_eos1_sw", CW'(switch_output), 1);
    chk("lit_eos1_stall", CW'(stall), 0);
    cyc(0, 0, 1, 1, 0, 1, 0);
    chk("lit_eos2_sel", CW'(select_A), 0);
    chk("lit_eos2_sw", CW'(switch_output), 0);
    chk("lit_eos2_stall", CW'(stall), 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("lit_eos_cnt", o_stream_count, 1);
    cyc(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 0, 0, 1);
      chk("lit_termb_stall", CW'(stall), 1);
      chk("lit_termb_sw", CW'(switch_output), 0);
    end
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0);
    chk("lit_rst_mid_cnt", o_stream_count, 0);
    chk("lit_rst_mid_run", CW'(switch_output), 1);
    for (int i = 0; i < (1 << CW); i++) begin
      cyc(0, 0, 1, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 1, 0);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("lit_wrap_cnt", o_stream_count, 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(49) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
          $urandom_range(4) == 0, 1'($urandom), $urandom_range(3) == 0, $urandom_range(3) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/merger_select_ctrl.md
Name: merger_select_ctrl

Overview:
- Selection and flow-control FSM for one 2-to-1 merger node of the sorted-record merge tree.
- Watches the head batches of input FIFOs A and B. Each batch is 16 sorted tuples; the merger's compare logic provides the head-tuple flags.
- Each cycle it decides which FIFO supplies the next batch to the bitonic network, whether the pipeline advances, and when to flush at end-of-stream.
- An all-zero head tuple is the end-of-stream terminator. A terminator compares as larger than any real key.

Parameters:
COUNT_WIDTH, 16, width of the completed-stream counter.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  reset; synchronous, active-high.
i_fifo_out_full  input  1  downstream cannot accept; the merger drives this from the registered ready, inverted.
i_a_min_zero  input  1  head tuple of FIFO A is all-zero (terminator).
i_b_min_zero  input  1  head tuple of FIFO B is all-zero (terminator).
i_a_lte_b  input  1  head key of A <= head key of B (unsigned).
i_a_empty  input  1  FIFO A empty.
i_b_empty  input  1  FIFO B empty.
select_A  output  1  1 = dequeue/forward A's head batch; 0 = B's. Meaningful only when stall=0.
stall  output  1  1 = no dequeue, pipeline holds this cycle.
switch_output  output  1  1 = the network emits its upper (bigger) half for this batch (flush).
o_stream_count  output  COUNT_WIDTH  number of completed end-of-stream sequences; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Outputs select_A, stall and switch_output are combinational from state and inputs. State and o_stream_count are registered.
- Two states: RUN (reset state) and TERM_B.
- While i_rst=1:
  - stall=1, select_A=0, switch_output=0, regardless of inputs.
  - On the clock edge, state becomes RUN and o_stream_count becomes 0.
  - Reset mid-sequence (in TERM_B) returns to RUN with no count increment.
- RUN:
  - stall = i_fifo_out_full | i_a_empty | i_b_empty. Both heads are required to decide, even if one is a terminator.
  - Selection priority:
    1. a_zero & b_zero: select_A=1, switch_output=1. If stall=0, next state is TERM_B.
    2. a_zero only: select_A=0 (A held at terminator until B finishes).
    3. b_zero only: select_A=1.
    4. Otherwise select_A = i_a_lte_b (tie goes to A).
  - switch_output=0 in all cases except 1.
- TERM_B:
  - select_A=0, switch_output=0.
  - stall = i_fifo_out_full | i_b_empty. A's emptiness is ignored.
  - If stall=0: next state is RUN and o_stream_count increments.
- When stall=1, state and count hold. Outputs still reflect current inputs each cycle.
- Exactly one dequeue per non-stalled cycle; never a dequeue on a stalled cycle.
- A full end-of-stream sequence:
  - A's terminator is consumed with switch_output=1.
  - Then B's terminator is consumed with switch_output=0.
  - This forwards one terminator downstream after the flush.
- i_a_lte_b is don't-care whenever either min_zero flag is set.

Decomposition:
- Shared package: state encoding constants (RUN=1'b0, TERM_B=1'b1). Batch size constant 16 and tuple DATA_WIDTH=128 / KEY_WIDTH=80 defaults, reused by the FIFO and bitonic-network blocks.
- No sub-module. One registered state/counter process plus one combinational output process.

Test Plan:
- Reset: i_rst=1 with all inputs 0 -> stall=1, select_A=0, switch_output=0. After release, RUN and o_stream_count=0.
- Normal compare: both non-empty, not zero, full=0. i_a_lte_b=1 -> select_A=1, stall=0; i_a_lte_b=0 -> select_A=0; count unchanged.
- Empty/full stall: i_b_empty=1 in RUN -> stall=1. Set full=1 with both non-empty -> stall=1. State unchanged in both cases.
- One-sided terminator: a_zero=1, b_zero=0, a_lte_b=1 -> select_A=0. Swap flags -> select_A=1. switch_output=0 in both.
- End-of-stream: both zero, non-empty -> cycle 1: select_A=1, switch_output=1, stall=0. Cycle 2 (TERM_B, A empty): select_A=0, stall=0. Then RUN, o_stream_count=1.
- TERM_B stall and reset: in TERM_B hold i_b_empty=1 for 3 cycles -> stall=1, state held. Assert i_rst -> RUN, count 0. Run 65536 sequences -> count wraps to 0.
